// File: rtl/mux32_sched_pkg.sv
// Shared types and widths for the 32:1 mux round-robin scheduler.
package mux32_sched_pkg;

    localparam int unsigned SEL_W = 5;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_t;

endpackage

// File: rtl/rr_pick32.sv
// Rotating-priority encoder: first set req bit scanning upward from last_ptr+1 (mod 32).
module rr_pick32
    import mux32_sched_pkg::*;
(
    input  logic [31:0]      req,
    input  logic [SEL_W-1:0] last_ptr,
    output logic [SEL_W-1:0] pick,
    output logic             any
);

    logic [SEL_W-1:0] idx;

    always_comb begin
        pick = '0;
        idx  = '0;
        any  = |req;
        // Walk from farthest to nearest offset so the nearest set bit wins.
        for (int i = 32; i >= 1; i--) begin
            idx = last_ptr + SEL_W'(i);
            if (req[idx]) begin
                pick = idx;
            end
        end
    end

endmodule

// File: rtl/mux32_rr_scheduler.sv
// Round-robin burst scheduler driving the 32:1 mux select with a TURN settle bubble.
// Optional stall timeout enabled by defining MUX32_SCHED_TIMEOUT_EN.
module mux32_rr_scheduler
    import mux32_sched_pkg::*;
#(
    parameter int unsigned N_SRC     = 32,
    parameter int unsigned MAX_BURST = 8,
    parameter int unsigned TIMEOUT   = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] req,
    output logic [SEL_W-1:0] sel,
    output logic [N_SRC-1:0] gnt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] beat_cnt,
    output logic             timeout_err
);

    if (N_SRC != 32) begin : g_bad_nsrc
        $error("N_SRC must be 32");
    end
    if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_burst
        $error("MAX_BURST must be 1..255");
    end
    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("TIMEOUT must be at least 2");
    end

    state_t           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [N_SRC-1:0] gnt_q, gnt_d;
    logic             out_valid_q, out_valid_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [SEL_W-1:0] last_ptr_q, last_ptr_d;

    logic [SEL_W-1:0] pick;
    logic             any;
    logic             beat;
    logic             timed_out;
    logic             release_grant;

    rr_pick32 u_pick (
        .req      (req),
        .last_ptr (last_ptr_q),
        .pick     (pick),
        .any      (any)
    );

    assign beat = (state_q == GRANT) && out_valid_q && out_ready;

`ifdef MUX32_SCHED_TIMEOUT_EN
    localparam int unsigned StallW = $clog2(TIMEOUT);

    logic [StallW-1:0] stall_q, stall_d;

    always_comb begin
        stall_d   = stall_q;
        timed_out = 1'b0;
        if (state_q == IDLE && any) begin
            stall_d = '0;
        end else if (state_q == GRANT) begin
            if (beat) begin
                stall_d = '0;
            end else if (out_valid_q && !out_ready) begin
                // The cycle that would be stall number TIMEOUT revokes the grant.
                if (stall_q == StallW'(TIMEOUT - 1)) begin
                    timed_out = 1'b1;
                end else begin
                    stall_d = stall_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end
`else
    assign timed_out = 1'b0;
`endif

    assign release_grant = (beat && (beat_cnt_q + 8'd1 == CNT_W'(MAX_BURST)))
                         || !req[sel_q] || timed_out;

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        gnt_d       = gnt_q;
        out_valid_d = out_valid_q;
        beat_cnt_d  = beat_cnt_q;
        last_ptr_d  = last_ptr_q;
        unique case (state_q)
            IDLE: begin
                if (any) begin
                    state_d     = GRANT;
                    sel_d       = pick;
                    gnt_d       = N_SRC'(1) << pick;
                    out_valid_d = 1'b1;
                    beat_cnt_d  = '0;
                end
            end
            GRANT: begin
                if (beat && beat_cnt_q != CNT_W'(MAX_BURST)) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                end
                if (release_grant) begin
                    state_d     = TURN;
                    last_ptr_d  = sel_q;
                    gnt_d       = '0;
                    out_valid_d = 1'b0;
                end
            end
            TURN: begin
                state_d = IDLE;
            end
            default: begin
                state_d     = IDLE;
                gnt_d       = '0;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            gnt_q       <= '0;
            out_valid_q <= 1'b0;
            beat_cnt_q  <= '0;
            last_ptr_q  <= 5'd31;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            gnt_q       <= gnt_d;
            out_valid_q <= out_valid_d;
            beat_cnt_q  <= beat_cnt_d;
            last_ptr_q  <= last_ptr_d;
        end
    end

    assign sel         = sel_q;
    assign gnt         = gnt_q;
    assign out_valid   = out_valid_q;
    assign beat_cnt    = beat_cnt_q;
    assign timeout_err = timed_out;

endmodule

// File: tb/tb_mux32_rr_scheduler.sv
// Bench for mux32_rr_scheduler: directed scenarios plus random traffic against a
// grant-level reference model. Honours MUX32_SCHED_TIMEOUT_EN like the design.
module tb_mux32_rr_scheduler;

    localparam int MaxBurst = 8;
    localparam int Timeout  = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] req;
    logic [4:0]  sel;
    logic [31:0] gnt;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  beat_cnt;
    logic        timeout_err;

    always #5 clk = ~clk;

    mux32_rr_scheduler #(
        .N_SRC     (32),
        .MAX_BURST (MaxBurst),
        .TIMEOUT   (Timeout)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .sel         (sel),
        .gnt         (gnt),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .beat_cnt    (beat_cnt),
        .timeout_err (timeout_err)
    );

    int vectors    = 0;
    int miscompares = 0;

    // Model: current owner (-1 none), last shown select, last served source,
    // beats and consecutive stalls in this grant, dead cycles before re-arbitration.
    int m_owner, m_sel, m_last, m_beats, m_stall, m_wait;

    function automatic int rr_pick(input logic [31:0] r, input int last);
        for (int k = 1; k <= 32; k++) begin
            if (r[(last + k) % 32]) return (last + k) % 32;
        end
        return -1;
    endfunction

    function automatic logic exp_timeout();
`ifdef MUX32_SCHED_TIMEOUT_EN
        return (m_owner >= 0) && !out_ready && (m_stall + 1 == Timeout);
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        m_owner = -1; m_sel = 0; m_last = 31; m_beats = 0; m_stall = 0; m_wait = 0;
    endtask

    task automatic model_edge();
        int  p;
        logic done;
        if (rst) begin
            model_reset();
        end else if (m_owner >= 0) begin
            done = exp_timeout();
            if (out_ready) begin
                m_beats = (m_beats + 1 > MaxBurst) ? MaxBurst : m_beats + 1;
                m_stall = 0;
                if (m_beats == MaxBurst) done = 1'b1;
            end else begin
                m_stall++;
            end
            if (!req[m_owner]) done = 1'b1;
            if (done) begin
                m_last  = m_owner;
                m_owner = -1;
                m_wait  = 1;
            end
        end else if (m_wait > 0) begin
            m_wait--;
        end else begin
            p = rr_pick(req, m_last);
            if (p >= 0) begin
                m_owner = p; m_sel = p; m_beats = 0; m_stall = 0;
            end
        end
    endtask

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [31:0] eg;
        eg = (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
        cmp({tag, ".sel"}, {27'd0, sel}, m_sel);
        cmp({tag, ".gnt"}, gnt, eg);
        cmp({tag, ".valid"}, {31'd0, out_valid}, {31'd0, m_owner >= 0});
        cmp({tag, ".beats"}, {24'd0, beat_cnt}, m_beats);
        cmp({tag, ".terr"}, {31'd0, timeout_err}, {31'd0, exp_timeout()});
    endtask

    // Called at a negedge; drives inputs, checks, advances one clock, returns at negedge.
    task automatic cycle(input string tag, input logic [31:0] r, input logic rdy);
        req = r;
        out_ready = rdy;
        #1;
        check_all(tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check_all("reset");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [4:0]  seq[$];
    logic        prevg;
    int          pulses;
    logic [31:0] rr;

    initial begin
        rst = 1'b1;
        req = '0;
        out_ready = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset();

        // 1: single requester, full burst, bubble, re-grant.
        cycle("t1", 32'h1, 1'b1);
        cmp("t1_sel", {27'd0, sel}, 0);
        cmp("t1_gnt", gnt, 32'h1);
        repeat (12) cycle("t1", 32'h1, 1'b1);

        // 2: two requesters at the extremes alternate.
        do_reset();
        prevg = 1'b0;
        repeat (44) begin
            cycle("t2", 32'h8000_0001, 1'b1);
            if (gnt != 0 && !prevg) seq.push_back(sel);
            prevg = (gnt != 0);
        end
        cmp("t2_seq0", {27'd0, seq[0]}, 0);
        cmp("t2_seq1", {27'd0, seq[1]}, 31);
        cmp("t2_seq2", {27'd0, seq[2]}, 0);
        cmp("t2_seq3", {27'd0, seq[3]}, 31);

        // 3: source 5 drops request after 3 beats.
        do_reset();
        cycle("t3", 32'h220, 1'b1);
        repeat (3) cycle("t3", 32'h220, 1'b1);
        cycle("t3", 32'h200, 1'b0);
        cmp("t3_beats", {24'd0, beat_cnt}, 3);
        cmp("t3_rel", gnt, 32'h0);
        cycle("t3", 32'h200, 1'b1);
        cycle("t3", 32'h200, 1'b1);
        cmp("t3_next", {27'd0, sel}, 9);

        // 4: all requesting, stall then drain, next source is prev+1.
        do_reset();
        cycle("t4", '1, 1'b1);
        repeat (10) cycle("t4", '1, 1'b0);
        cmp("t4_stall_beats", {24'd0, beat_cnt}, 0);
        cmp("t4_stall_sel", {27'd0, sel}, 0);
        repeat (8) cycle("t4", '1, 1'b1);
        cycle("t4", '1, 1'b1);
        cycle("t4", '1, 1'b1);
        cmp("t4_next", {27'd0, sel}, 1);

        // 5: long stall; timeout only with the feature enabled.
        do_reset();
        cycle("t5", 32'h1, 1'b0);
        pulses = 0;
        repeat (70) begin
            cycle("t5", 32'h1, 1'b0);
            if (timeout_err) pulses++;
        end
`ifdef MUX32_SCHED_TIMEOUT_EN
        cmp("t5_pulses", pulses, 1);
`else
        cmp("t5_pulses", pulses, 0);
`endif

        // 6: asynchronous reset in the middle of a grant.
        do_reset();
        repeat (3) cycle("t6", 32'h88, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        cmp("t6_sel", {27'd0, sel}, 0);
        cmp("t6_gnt", gnt, 32'h0);
        cmp("t6_valid", {31'd0, out_valid}, 0);
        cmp("t6_beats", {24'd0, beat_cnt}, 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cycle("t6", 32'h88, 1'b1);
        cmp("t6_first", {27'd0, sel}, 3);

        // Random traffic with sticky requests and occasional resets.
        rr = $urandom & $urandom;
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                rr = ($urandom_range(0, 7) == 0) ? 32'h0 : ($urandom & $urandom);
            end
            if ($urandom_range(0, 199) == 0) do_reset();
            cycle("rand", rr, $urandom_range(0, 3) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
